caravel_hkspi: RTL and testbench

Housekeeping SPI slave of the Caravel management area: a 4-wire SPI target, oversampled by the system clock, that exposes a byte-addressed register file. The file holds identification constants, PLL/clock configuration and the user-project external reset. It sits between the housekeeping pads (mprj_io[4:1]) and the PLL/reset logic, and it works independently of the management CPU.

---
 rtl/caravel_hkspi_pkg.sv | 52 +++++
 rtl/caravel_hkspi_sync.sv | 48 ++++
 rtl/caravel_hkspi.sv | 166 ++++++++++++++++
 tb/tb_caravel_hkspi.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_hkspi_pkg.sv
// Shared definitions for the housekeeping SPI slave: command/state encodings,
// register map constants, the cfg reset vector and the read-mux helper.
package caravel_hkspi_pkg;

  localparam logic [11:0] MFGR_ID  = 12'h456;
  localparam logic [7:0]  PROD_ID  = 8'h20;
  localparam logic [31:0] MASK_REV = 32'h0;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_RW  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA
  } state_e;

  localparam logic [7:0] ADDR_PROD_ID   = 8'h03;
  localparam logic [7:0] ADDR_EXT_RESET = 8'h0B;
  localparam logic [7:0] ADDR_CFG_FIRST = 8'h08;
  localparam logic [7:0] ADDR_CFG_LAST  = 8'h12;

  localparam int CFG_REGS      = 11;
  localparam int EXT_RESET_BIT = 24;  // reg 0x0B bit 0 inside the packed cfg vector

  localparam logic [87:0] CFG_RESET = 88'h04_12_03_FF_EF_FF_00_00_00_01_02;

  function automatic logic [7:0] read_reg(input logic [7:0] addr, input logic [87:0] cfg);
    logic [7:0] data;
    data = 8'h00;
    case (addr)
      8'h01:        data = {4'h0, MFGR_ID[11:8]};
      8'h02:        data = MFGR_ID[7:0];
      ADDR_PROD_ID: data = PROD_ID;
      8'h04:        data = MASK_REV[31:24];
      8'h05:        data = MASK_REV[23:16];
      8'h06:        data = MASK_REV[15:8];
      8'h07:        data = MASK_REV[7:0];
      default:      data = 8'h00;
    endcase
    for (int i = 0; i < CFG_REGS; i++) begin
      if (addr == ADDR_CFG_FIRST + 8'(i)) data = cfg[i*8 +: 8];
    end
    return data;
  endfunction

endpackage

// File: rtl/caravel_hkspi_sync.sv
// Two-flop synchronizer followed by a two-sample agreement filter; reports the
// filtered level and a one-clock pulse whenever that level changes.
module hkspi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic changed
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;
  logic level_q, level_d;
  logic changed_q, changed_d;

  // A pulse shorter than two clocks never shows in both sync_q and hist_q.
  always_comb begin
    meta_d    = d;
    sync_d    = meta_q;
    hist_d    = sync_q;
    level_d   = (sync_q == hist_q) ? sync_q : level_q;
    changed_d = (level_d != level_q);
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      meta_q    <= RESET_VAL;
      sync_q    <= RESET_VAL;
      hist_q    <= RESET_VAL;
      level_q   <= RESET_VAL;
      changed_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      level_q   <= level_d;
      changed_q <= changed_d;
    end
  end

  assign level   = level_q;
  assign changed = changed_q;

endmodule

// File: rtl/caravel_hkspi.sv
// Housekeeping SPI slave, oversampled by clock. Define HKSPI_RW_STREAM_EN to make
// command 11 read-then-write; otherwise command 11 is a plain read stream.
module caravel_hkspi
  import caravel_hkspi_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        sck,
  input  logic        csb,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic        ext_reset,
  output logic [87:0] cfg
);

  logic sck_lvl, sck_chg, csb_lvl, csb_chg;
  logic sck_rise, sck_fall, csb_fall;

  hkspi_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .clock  (clock),
    .reset  (reset),
    .d      (sck),
    .level  (sck_lvl),
    .changed(sck_chg)
  );

  hkspi_sync #(.RESET_VAL(1'b1)) u_csb_sync (
    .clock  (clock),
    .reset  (reset),
    .d      (csb),
    .level  (csb_lvl),
    .changed(csb_chg)
  );

  assign sck_rise = sck_chg & sck_lvl;
  assign sck_fall = sck_chg & ~sck_lvl;
  assign csb_fall = csb_chg & ~csb_lvl;

  logic        sdi_meta_q, sdi_meta_d;
  logic        sdi_sync_q, sdi_sync_d;
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_in_q, shift_in_d;
  cmd_e        cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic        sdo_q, sdo_d;
  logic        sdo_oe_q, sdo_oe_d;
  logic [87:0] cfg_q, cfg_d;
  logic        ext_reset_q, ext_reset_d;

  logic [7:0] in_byte;
  logic [7:0] rd_byte;
  logic       rd_en;
  logic       wr_en;

  assign rd_en = (cmd_q == CMD_RD) || (cmd_q == CMD_RW);
`ifdef HKSPI_RW_STREAM_EN
  assign wr_en = (cmd_q == CMD_WR) || (cmd_q == CMD_RW);
`else
  assign wr_en = (cmd_q == CMD_WR);
`endif

  always_comb begin
    // NOTE: every _d gets its default first, so no path infers a latch.
    sdi_meta_d  = sdi;
    sdi_sync_d  = sdi_meta_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    shift_out_d = shift_out_q;
    sdo_d       = sdo_q;
    sdo_oe_d    = sdo_oe_q;
    cfg_d       = cfg_q;
    ext_reset_d = cfg_q[EXT_RESET_BIT];
    in_byte     = {shift_in_q[6:0], sdi_sync_q};
    rd_byte     = read_reg(addr_q, cfg_q);

    if (csb_lvl) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sdo_d     = 1'b0;
      sdo_oe_d  = 1'b0;
    end else if (csb_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
    end else if (state_q != ST_IDLE) begin
      if (sck_rise) begin
        shift_in_d = in_byte;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              cmd_d   = cmd_e'(in_byte[7:6]);
              state_d = ST_ADDR;
            end
            ST_ADDR: begin
              addr_d  = in_byte;
              state_d = ST_DATA;
            end
            ST_DATA: begin
              if (wr_en && addr_q >= ADDR_CFG_FIRST && addr_q <= ADDR_CFG_LAST) begin
                for (int i = 0; i < CFG_REGS; i++) begin
                  if (addr_q == ADDR_CFG_FIRST + 8'(i))
                    cfg_d[i*8 +: 8] = (addr_q == ADDR_EXT_RESET) ? {7'b0, in_byte[0]} : in_byte;
                end
              end
              addr_d = addr_q + 8'd1;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end else if (sck_fall && state_q == ST_DATA && rd_en) begin
        // bit_cnt of 0 on a falling edge means a fresh byte starts here.
        if (bit_cnt_q == 3'd0) begin
          sdo_d       = rd_byte[7];
          shift_out_d = {rd_byte[6:0], 1'b0};
          sdo_oe_d    = 1'b1;
        end else begin
          sdo_d       = shift_out_q[7];
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sdi_meta_q  <= 1'b0;
      sdi_sync_q  <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'h00;
      cmd_q       <= CMD_NOP;
      addr_q      <= 8'h00;
      shift_out_q <= 8'h00;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      // NOTE: cfg is plain flop state, not a RAM, so it reloads its reset image.
      cfg_q       <= CFG_RESET;
      ext_reset_q <= 1'b0;
    end else begin
      sdi_meta_q  <= sdi_meta_d;
      sdi_sync_q  <= sdi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      shift_out_q <= shift_out_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      cfg_q       <= cfg_d;
      ext_reset_q <= ext_reset_d;
    end
  end

  assign sdo       = sdo_q;
  assign sdo_oe    = sdo_oe_q;
  assign ext_reset = ext_reset_q;
  assign cfg       = cfg_q;

endmodule

// File: tb/tb_caravel_hkspi.sv
// Bench for caravel_hkspi: spec-constant vector table, hand-written corner
// sequences, then random transactions against a byte-array register model.
module tb_caravel_hkspi;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sck   = 1'b0;
  logic        csb   = 1'b1;
  logic        sdi   = 1'b0;
  logic        sdo, sdo_oe, ext_reset;
  logic [87:0] cfg;

  int checks   = 0;
  int failures = 0;

  localparam logic [87:0] CFG_RST = 88'h04_12_03_FF_EF_FF_00_00_00_01_02;
`ifdef HKSPI_RW_STREAM_EN
  localparam bit RW_EN = 1'b1;
`else
  localparam bit RW_EN = 1'b0;
`endif

  caravel_hkspi dut (
    .clock    (clock),
    .reset    (reset),
    .sck      (sck),
    .csb      (csb),
    .sdi      (sdi),
    .sdo      (sdo),
    .sdo_oe   (sdo_oe),
    .ext_reset(ext_reset),
    .cfg      (cfg)
  );

  always #10 clock = ~clock;

  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [18];
  logic [7:0] mem [256];
  logic [7:0] exp19 [19] = '{8'h00, 8'h04, 8'h56, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hEF, 8'hFF,
                             8'h03, 8'h12, 8'h04};
  logic [7:0] rx, rx2;

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All bus timing uses multiples of 20 ns from a point 5 ns before a rising clock.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi = tx[i];
      #100;
      rxb[i] = sdo;
      sck = 1'b1;
      #100;
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rxb);
    xfer_bits(tx, 8, rxb);
  endtask

  task automatic spi_begin();
    csb = 1'b0;
    #200;
  endtask

  task automatic spi_end();
    #100;
    csb = 1'b1;
    sdi = 1'b0;
    #160;
    check("sdo_oe_after_csb", sdo_oe, 1'b0);
    check("sdo_after_csb", sdo, 1'b0);
  endtask

  task automatic single(input logic [7:0] cmd, input logic [7:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rxb);
    logic [7:0] dummy;
    spi_begin();
    xfer(cmd, dummy);
    xfer(addr, dummy);
    xfer(wdata, rxb);
    spi_end();
  endtask

  task automatic model_init();
    logic [87:0] v;
    v = CFG_RST;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'h04;
    mem[2] = 8'h56;
    mem[3] = 8'h20;
    for (int i = 0; i < 11; i++) mem[8 + i] = v[i*8 +: 8];
  endtask

  task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
    if (a >= 8'h08 && a <= 8'h12) mem[a] = (a == 8'h0B) ? {7'b0, d[0]} : d;
  endtask

  function automatic logic [87:0] model_cfg();
    logic [87:0] v;
    for (int i = 0; i < 11; i++) v[i*8 +: 8] = mem[8 + i];
    return v;
  endfunction

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int n);
    logic [7:0] a, d, exp, got, dummy;
    spi_begin();
    xfer(cmd, dummy);
    xfer(addr, dummy);
    a = addr;
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      xfer(d, got);
      exp = 8'h00;
      case (cmd[7:6])
        2'b01: exp = mem[a];
        2'b10: model_wr(a, d);
        2'b11: begin
          exp = mem[a];
          if (RW_EN) model_wr(a, d);
        end
        default: exp = 8'h00;
      endcase
      check($sformatf("rand_c%0h_a%0h", cmd[7:6], a), got, exp);
      a = a + 8'd1;
    end
    spi_end();
    #40;
    check("rand_cfg", cfg, model_cfg());
    check("rand_ext_reset", ext_reset, mem[8'h0B][0]);
  endtask

  initial begin
    tbl[0]  = '{"rd_prod",       8'h40, 8'h03, 8'h00, 8'h20};
    tbl[1]  = '{"rd_mfgr_hi",    8'h7F, 8'h01, 8'h00, 8'h04};
    tbl[2]  = '{"rd_mfgr_lo",    8'h40, 8'h02, 8'h00, 8'h56};
    tbl[3]  = '{"rd_cfg08",      8'h40, 8'h08, 8'h00, 8'h02};
    tbl[4]  = '{"rd_cfg0e",      8'h40, 8'h0E, 8'h00, 8'hEF};
    tbl[5]  = '{"rd_cfg12",      8'h40, 8'h12, 8'h00, 8'h04};
    tbl[6]  = '{"rd_unmapped13", 8'h40, 8'h13, 8'h00, 8'h00};
    tbl[7]  = '{"rd_unmappedff", 8'h40, 8'hFF, 8'h00, 8'h00};
    tbl[8]  = '{"wr_prod_drop",  8'h80, 8'h03, 8'h99, 8'h00};
    tbl[9]  = '{"rd_prod_kept",  8'h40, 8'h03, 8'h00, 8'h20};
    tbl[10] = '{"wr_cfg0c",      8'h80, 8'h0C, 8'h5A, 8'h00};
    tbl[11] = '{"rd_cfg0c",      8'h40, 8'h0C, 8'h00, 8'h5A};
    tbl[12] = '{"nop_cfg0c",     8'h00, 8'h0C, 8'h77, 8'h00};
    tbl[13] = '{"rd_after_nop",  8'h40, 8'h0C, 8'h00, 8'h5A};
    tbl[14] = '{"wr_0b_ff",      8'h80, 8'h0B, 8'hFF, 8'h00};
    tbl[15] = '{"rd_0b_masked",  8'h40, 8'h0B, 8'h00, 8'h01};
    tbl[16] = '{"rw_cfg0c_old",  8'hC0, 8'h0C, 8'h33, 8'h5A};
    tbl[17] = '{"rd_after_rw",   8'h40, 8'h0C, 8'h00, RW_EN ? 8'h33 : 8'h5A};

    @(negedge clock);
    #5;
    reset = 1'b1;
    #100;
    reset = 1'b0;
    #100;
    check("rst_sdo", sdo, 1'b0);
    check("rst_sdo_oe", sdo_oe, 1'b0);
    check("rst_ext_reset", ext_reset, 1'b0);
    check("rst_cfg", cfg, CFG_RST);

    spi_begin();
    xfer(8'h40, rx);
    xfer(8'h00, rx);
    for (int i = 0; i < 19; i++) begin
      xfer(8'h00, rx);
      check($sformatf("stream_byte%0d", i), rx, exp19[i]);
    end
    spi_end();

    for (int i = 0; i < 18; i++) begin
      single(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, rx);
      check(tbl[i].name, rx, tbl[i].exp);
    end

    single(8'h80, 8'h0B, 8'h01, rx);
    #40;
    check("ext_reset_set", ext_reset, 1'b1);
    single(8'h80, 8'h0B, 8'h00, rx);
    #40;
    check("ext_reset_clr", ext_reset, 1'b0);
    single(8'h40, 8'h0B, 8'h00, rx);
    check("rd_0b_clr", rx, 8'h00);

    spi_begin();
    xfer(8'h80, rx);
    xfer(8'h10, rx);
    xfer(8'hAA, rx);
    xfer(8'h55, rx);
    spi_end();
    spi_begin();
    xfer(8'h40, rx);
    xfer(8'h10, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx2);
    spi_end();
    check("rd_cfg10", rx, 8'hAA);
    check("rd_cfg11", rx2, 8'h55);
    check("cfg_10_11", cfg[79:64], 16'h55AA);

    spi_begin();
    xfer(8'h80, rx);
    xfer(8'h0D, rx);
    xfer_bits(8'h00, 4, rx);
    spi_end();
    spi_begin();
    xfer(8'h40, rx);
    xfer(8'h0D, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx2);
    spi_end();
    check("abort_kept_0d", rx, 8'hFF);
    check("abort_next_0e", rx2, 8'hEF);

    single(8'h80, 8'h0B, 8'h01, rx);
    spi_begin();
    xfer(8'h40, rx);
    xfer(8'h08, rx);
    xfer_bits(8'h00, 3, rx);
    check("oe_mid_read", sdo_oe, 1'b1);
    reset = 1'b1;
    #60;
    check("midrst_sdo", sdo, 1'b0);
    check("midrst_sdo_oe", sdo_oe, 1'b0);
    check("midrst_cfg", cfg, CFG_RST);
    check("midrst_ext_reset", ext_reset, 1'b0);
    csb = 1'b1;
    #100;
    reset = 1'b0;
    #100;
    single(8'h40, 8'h03, 8'h00, rx);
    check("post_rst_prod", rx, 8'h20);

    model_init();
    for (int t = 0; t < 40; t++) begin
      logic [7:0] cmd, addr;
      cmd  = 8'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? 8'(8'hFD + $urandom_range(0, 2))
                                         : 8'($urandom_range(0, 23));
      run_txn(cmd, addr, $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
